hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the stall inputs of the fetch/issue pipe registers, the clr input of the issue-execute pipe register, and the EX-stage operand forwarding selects. It also schedules the shared multi-cycle multiply/divide unit (MDU), holding issue while the MDU is busy or while HI/LO results are pending.

Parameters:
MUL_LAT, 4, MDU busy cycles for mult/multu (legal range 1..63)
DIV_LAT, 32, MDU busy cycles for div/divu (legal range 1..63)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_id_i  in  1  instruction in ID is valid
rs_id_i  in  5  ID source register rs
rt_id_i  in  5  ID source register rt
mdu_start_id_i  in  1  ID instruction is mult/multu/div/divu
mdu_is_div_id_i  in  1  ID MDU op is a divide (selects DIV_LAT)
mfhilo_id_i  in  1  ID instruction is mfhi/mflo
valid_ex_i  in  1  EX stage valid (from ex pipe reg)
rs_ex_i  in  5  EX rs
rt_ex_i  in  5  EX rt
wr_reg_ex_i  in  5  EX destination after reg_dst mux
reg_wr_ex_i  in  1  EX writes a register
mem_to_reg_ex_i  in  1  EX instruction is a load
valid_mem_i, reg_wr_mem_i  in  1 each  MEM stage valid / register write
wr_reg_mem_i  in  5  MEM destination
valid_wb_i, reg_wr_wb_i  in  1 each  WB stage valid / register write
wr_reg_wb_i  in  5  WB destination
branch_taken_ex_i  in  1  taken branch/jump resolved in EX
stall_if_o  out  1  hold PC and IF/ID register
stall_id_o  out  1  hold ID stage
clr_id_o  out  1  flush IF/ID register
clr_ex_o  out  1  insert bubble into issue-execute register (drives its clr)
fwd_a_o  out  2  EX operand A select
fwd_b_o  out  2  EX operand B select
mdu_busy_o  out  1  MDU operation in flight
mdu_done_o  out  1  one-cycle pulse: HI/LO valid

Behaviour:
- Reset (synchronous): FSM to IDLE, counter to 0. While reset is high, all outputs are 0 except clr_id_o=1 and clr_ex_o=1.
- Forwarding (combinational): encoding 00 = regfile, 01 = WB, 10 = MEM. For src in {rs_ex_i, rt_ex_i}: if valid_mem_i & reg_wr_mem_i & wr_reg_mem_i!=0 & wr_reg_mem_i==src, select 10. Else if the same condition holds for WB, select 01. Else select 00. MEM has priority over WB. Register 0 is never forwarded.
- Load-use (lu): valid_id_i & valid_ex_i & mem_to_reg_ex_i & wr_reg_ex_i!=0 & (wr_reg_ex_i==rs_id_i | wr_reg_ex_i==rt_id_i).
- MDU hazard (mh): valid_id_i & (mdu_start_id_i | mfhilo_id_i) & state==BUSY.
- stall = lu | mh. When stall is 1: stall_if_o=1, stall_id_o=1, clr_ex_o=1.
- Branch: branch_taken_ex_i=1 forces clr_id_o=1 and clr_ex_o=1, and forces stall_if_o=0 and stall_id_o=0 (flush overrides stall).
- MDU FSM states: IDLE, BUSY, DONE.
  - start = valid_id_i & mdu_start_id_i & !stall & !branch_taken_ex_i.
  - IDLE or DONE, with start: go to BUSY; counter loads (mdu_is_div_id_i ? DIV_LAT : MUL_LAT) - 1.
  - IDLE, no start: stay in IDLE.
  - DONE, no start: go to IDLE.
  - BUSY: counter decrements each cycle; when counter==0, go to DONE.
- MDU outputs: mdu_busy_o = (state==BUSY); mdu_done_o = (state==DONE).
- MDU latency: start accepted at edge N -> busy high for cycles N+1..N+LAT -> done high at cycle N+LAT+1. An mfhi/mflo stalled on BUSY is released in the DONE cycle.
- Back-to-back: a new MDU op in ID during BUSY stalls. In DONE it is accepted, done pulses once, and the FSM returns to BUSY.
- A taken branch never aborts an in-flight MDU op (its start was already past ID).
- Reset mid-BUSY returns to IDLE with no done pulse.
- Counter width: 6 bits.

Decomposition:
- Package hazard_pkg holds: FWD_RF / FWD_WB / FWD_MEM constants, the MDU FSM state encoding, and the counter width.
- Sub-module mdu_seq holds the FSM and counter. It takes start, is_div, clk, reset and outputs busy and done.
- Forwarding and stall logic stay combinational in the top module.

Test Plan:
- Fwd priority: MEM and WB both write r5, rs_ex=5 -> fwd_a_o=10. With MEM reg_wr=0 -> 01. With wr_reg=0 and rs_ex=0 -> 00.
- Load-use: lw r3 in EX (mem_to_reg=1, wr_reg_ex=3), ID rt=3 -> stall_if/stall_id/clr_ex=1 for exactly 1 cycle. Same case with wr_reg_ex=0 -> no stall.
- Div: start div with DIV_LAT=32 at cycle 10 -> busy high cycles 11..42, done at 43. mflo held in ID stalls cycles 11..42 and proceeds at 43.
- Mult then mult: second mult in ID during BUSY stalls until DONE, accepted in the DONE cycle -> busy high again the next cycle; MUL_LAT=4 gives busy 4 cycles each.
- Branch over stall: load-use and branch_taken_ex=1 in the same cycle -> stall_if=0, clr_id=1, clr_ex=1. Mult in ID in that cycle -> no start.
- Reset during BUSY (counter=17) -> next cycle busy=0, done never pulses, clr_ex=1 while reset high.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// MDU sequencer state encoding and counter width.
package hazard_pkg;

    localparam int CNT_W = 6;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    // MEM beats WB; r0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_reg,
        input logic       wb_wr,
        input logic [4:0] wb_reg
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_wr && (mem_reg != 5'd0) && (mem_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_reg != 5'd0) && (wb_reg == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multiply/divide unit sequencer: tracks one in-flight MDU operation with a
// down-counter and pulses done for one cycle when HI/LO become valid.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// MDU_IDLE | no operation in flight, HI/LO stable
// MDU_BUSY | operation running, counter holds remaining cycles minus one
// MDU_DONE | HI/LO valid this cycle; a new start may be accepted here
module mdu_seq
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MDU_IDLE, MDU_DONE: begin
                if (start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == MDU_BUSY);
    assign done = (state_q == MDU_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: EX operand
// forwarding, load-use and MDU interlocks, branch flush and MDU scheduling.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_id_i,
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    input  logic       mdu_start_id_i,
    input  logic       mdu_is_div_id_i,
    input  logic       mfhilo_id_i,
    input  logic       valid_ex_i,
    input  logic [4:0] rs_ex_i,
    input  logic [4:0] rt_ex_i,
    input  logic [4:0] wr_reg_ex_i,
    input  logic       reg_wr_ex_i,
    input  logic       mem_to_reg_ex_i,
    input  logic       valid_mem_i,
    input  logic       reg_wr_mem_i,
    input  logic [4:0] wr_reg_mem_i,
    input  logic       valid_wb_i,
    input  logic       reg_wr_wb_i,
    input  logic [4:0] wr_reg_wb_i,
    input  logic       branch_taken_ex_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       clr_id_o,
    output logic       clr_ex_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       mdu_busy_o,
    output logic       mdu_done_o
);

    logic load_use;
    logic mdu_haz;
    logic stall;
    logic mdu_start;
    logic mdu_busy;
    logic mdu_done;
    logic mem_wr;
    logic wb_wr;
    logic unused_reg_wr_ex;

    // A load always writes its destination, so only mem_to_reg matters here.
    assign unused_reg_wr_ex = reg_wr_ex_i;

    assign mem_wr = valid_mem_i & reg_wr_mem_i;
    assign wb_wr  = valid_wb_i & reg_wr_wb_i;

    assign load_use = valid_id_i & valid_ex_i & mem_to_reg_ex_i
                    & (wr_reg_ex_i != 5'd0)
                    & ((wr_reg_ex_i == rs_id_i) | (wr_reg_ex_i == rt_id_i));

    assign mdu_haz = valid_id_i & (mdu_start_id_i | mfhilo_id_i) & mdu_busy;

    assign stall = load_use | mdu_haz;

    // An MDU op squashed by a taken branch must not start.
    assign mdu_start = valid_id_i & mdu_start_id_i & ~stall & ~branch_taken_ex_i;

    mdu_seq #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_mdu_seq (
        .clk   (clk),
        .reset (reset),
        .start (mdu_start),
        .is_div(mdu_is_div_id_i),
        .busy  (mdu_busy),
        .done  (mdu_done)
    );

    always_comb begin
        stall_if_o = stall;
        stall_id_o = stall;
        clr_id_o   = 1'b0;
        clr_ex_o   = stall;
        fwd_a_o    = fwd_sel(rs_ex_i, mem_wr, wr_reg_mem_i, wb_wr, wr_reg_wb_i);
        fwd_b_o    = fwd_sel(rt_ex_i, mem_wr, wr_reg_mem_i, wb_wr, wr_reg_wb_i);
        mdu_busy_o = mdu_busy;
        mdu_done_o = mdu_done;

        // Flush wins over stall: the stalled ID instruction is being discarded.
        if (branch_taken_ex_i) begin
            stall_if_o = 1'b0;
            stall_id_o = 1'b0;
            clr_id_o   = 1'b1;
            clr_ex_o   = 1'b1;
        end

        if (reset) begin
            stall_if_o = 1'b0;
            stall_id_o = 1'b0;
            clr_id_o   = 1'b1;
            clr_ex_o   = 1'b1;
            fwd_a_o    = FWD_RF;
            fwd_b_o    = FWD_RF;
            mdu_busy_o = 1'b0;
            mdu_done_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a timestamp-based reference model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       valid_id, mdu_start_id, mdu_is_div_id, mfhilo_id;
    logic [4:0] rs_id, rt_id;
    logic       valid_ex, reg_wr_ex, mem_to_reg_ex;
    logic [4:0] rs_ex, rt_ex, wr_reg_ex;
    logic       valid_mem, reg_wr_mem, valid_wb, reg_wr_wb;
    logic [4:0] wr_reg_mem, wr_reg_wb;
    logic       branch_taken_ex;

    logic       stall_if, stall_id, clr_id, clr_ex, mdu_busy, mdu_done;
    logic [1:0] fwd_a, fwd_b;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_id_i       (valid_id),
        .rs_id_i          (rs_id),
        .rt_id_i          (rt_id),
        .mdu_start_id_i   (mdu_start_id),
        .mdu_is_div_id_i  (mdu_is_div_id),
        .mfhilo_id_i      (mfhilo_id),
        .valid_ex_i       (valid_ex),
        .rs_ex_i          (rs_ex),
        .rt_ex_i          (rt_ex),
        .wr_reg_ex_i      (wr_reg_ex),
        .reg_wr_ex_i      (reg_wr_ex),
        .mem_to_reg_ex_i  (mem_to_reg_ex),
        .valid_mem_i      (valid_mem),
        .reg_wr_mem_i     (reg_wr_mem),
        .wr_reg_mem_i     (wr_reg_mem),
        .valid_wb_i       (valid_wb),
        .reg_wr_wb_i      (reg_wr_wb),
        .wr_reg_wb_i      (wr_reg_wb),
        .branch_taken_ex_i(branch_taken_ex),
        .stall_if_o       (stall_if),
        .stall_id_o       (stall_id),
        .clr_id_o         (clr_id),
        .clr_ex_o         (clr_ex),
        .fwd_a_o          (fwd_a),
        .fwd_b_o          (fwd_b),
        .mdu_busy_o       (mdu_busy),
        .mdu_done_o       (mdu_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: the MDU op accepted at edge mdu_s is busy for mdu_lat cycles,
    // then done for exactly one cycle.
    longint cyc    = 0;
    longint mdu_s  = -1000;
    int     mdu_lat = 1;

    int o_stall_if, o_clr_id, o_clr_ex, o_fwd_a, o_busy, o_done;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ref_fwd(input logic [4:0] src);
        if (valid_mem && reg_wr_mem && wr_reg_mem != 0 && wr_reg_mem == src) return 2;
        if (valid_wb && reg_wr_wb && wr_reg_wb != 0 && wr_reg_wb == src) return 1;
        return 0;
    endfunction

    task automatic run_cycle();
        bit m_busy, m_done, lu, mh, stl, start;
        int e_sif, e_sid, e_cid, e_cex, e_fa, e_fb, e_busy, e_done;
        #3;
        m_busy = (cyc >= mdu_s) && (cyc < mdu_s + mdu_lat);
        m_done = (cyc == mdu_s + mdu_lat);
        lu = valid_id && valid_ex && mem_to_reg_ex && wr_reg_ex != 0
             && (wr_reg_ex == rs_id || wr_reg_ex == rt_id);
        mh = valid_id && (mdu_start_id || mfhilo_id) && m_busy;
        stl = lu || mh;
        start = !reset && valid_id && mdu_start_id && !stl && !branch_taken_ex;
        if (reset) begin
            e_sif = 0; e_sid = 0; e_cid = 1; e_cex = 1;
            e_fa = 0; e_fb = 0; e_busy = 0; e_done = 0;
        end else begin
            e_fa = ref_fwd(rs_ex);
            e_fb = ref_fwd(rt_ex);
            e_busy = int'(m_busy);
            e_done = int'(m_done);
            if (branch_taken_ex) begin
                e_sif = 0; e_sid = 0; e_cid = 1; e_cex = 1;
            end else begin
                e_sif = int'(stl); e_sid = int'(stl); e_cid = 0; e_cex = int'(stl);
            end
        end
        check_val("stall_if", int'(stall_if), e_sif);
        check_val("stall_id", int'(stall_id), e_sid);
        check_val("clr_id", int'(clr_id), e_cid);
        check_val("clr_ex", int'(clr_ex), e_cex);
        check_val("fwd_a", int'(fwd_a), e_fa);
        check_val("fwd_b", int'(fwd_b), e_fb);
        check_val("mdu_busy", int'(mdu_busy), e_busy);
        check_val("mdu_done", int'(mdu_done), e_done);
        o_stall_if = int'(stall_if);
        o_clr_id   = int'(clr_id);
        o_clr_ex   = int'(clr_ex);
        o_fwd_a    = int'(fwd_a);
        o_busy     = int'(mdu_busy);
        o_done     = int'(mdu_done);
        @(posedge clk);
        cyc++;
        if (reset) begin
            mdu_s = -1000;
        end else if (start) begin
            mdu_s   = cyc;
            mdu_lat = mdu_is_div_id ? DIV_LAT : MUL_LAT;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        valid_id = 1'b0; rs_id = 5'd0; rt_id = 5'd0;
        mdu_start_id = 1'b0; mdu_is_div_id = 1'b0; mfhilo_id = 1'b0;
        valid_ex = 1'b0; rs_ex = 5'd0; rt_ex = 5'd0; wr_reg_ex = 5'd0;
        reg_wr_ex = 1'b0; mem_to_reg_ex = 1'b0;
        valid_mem = 1'b0; reg_wr_mem = 1'b0; wr_reg_mem = 5'd0;
        valid_wb = 1'b0; reg_wr_wb = 1'b0; wr_reg_wb = 5'd0;
        branch_taken_ex = 1'b0;
    endtask

    task automatic rand_inputs();
        reset         = ($urandom_range(0, 99) == 0);
        valid_id      = ($urandom_range(0, 9) != 0);
        rs_id         = 5'($urandom_range(0, 3));
        rt_id         = 5'($urandom_range(0, 3));
        mdu_start_id  = ($urandom_range(0, 7) == 0);
        mdu_is_div_id = ($urandom_range(0, 3) == 0);
        mfhilo_id     = ($urandom_range(0, 5) == 0) && !mdu_start_id;
        valid_ex      = ($urandom_range(0, 4) != 0);
        rs_ex         = 5'($urandom_range(0, 3));
        rt_ex         = 5'($urandom_range(0, 3));
        wr_reg_ex     = 5'($urandom_range(0, 3));
        reg_wr_ex     = 1'($urandom_range(0, 1));
        mem_to_reg_ex = ($urandom_range(0, 2) == 0);
        valid_mem     = ($urandom_range(0, 4) != 0);
        reg_wr_mem    = 1'($urandom_range(0, 1));
        wr_reg_mem    = 5'($urandom_range(0, 3));
        valid_wb      = ($urandom_range(0, 4) != 0);
        reg_wr_wb     = 1'($urandom_range(0, 1));
        wr_reg_wb     = 5'($urandom_range(0, 3));
        branch_taken_ex = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;
        #1;
        run_cycle();
        run_cycle();
        check_val("reset_clr_ex", o_clr_ex, 1);

        // Forwarding priority
        idle_inputs();
        valid_mem = 1'b1; reg_wr_mem = 1'b1; wr_reg_mem = 5'd5;
        valid_wb = 1'b1; reg_wr_wb = 1'b1; wr_reg_wb = 5'd5; rs_ex = 5'd5;
        run_cycle();
        check_val("fwd_mem_prio", o_fwd_a, 2);
        reg_wr_mem = 1'b0;
        run_cycle();
        check_val("fwd_wb", o_fwd_a, 1);
        reg_wr_mem = 1'b1; wr_reg_mem = 5'd0; wr_reg_wb = 5'd0; rs_ex = 5'd0;
        run_cycle();
        check_val("fwd_r0", o_fwd_a, 0);

        // Load-use
        idle_inputs();
        valid_ex = 1'b1; mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; wr_reg_ex = 5'd3;
        valid_id = 1'b1; rt_id = 5'd3;
        run_cycle();
        check_val("lu_stall", o_stall_if, 1);
        valid_ex = 1'b0;
        run_cycle();
        check_val("lu_released", o_stall_if, 0);
        valid_ex = 1'b1; wr_reg_ex = 5'd0; rt_id = 5'd0;
        run_cycle();
        check_val("lu_r0", o_stall_if, 0);

        // Divide with mflo waiting in ID
        idle_inputs();
        valid_id = 1'b1; mdu_start_id = 1'b1; mdu_is_div_id = 1'b1;
        run_cycle();
        mdu_start_id = 1'b0; mdu_is_div_id = 1'b0; mfhilo_id = 1'b1;
        n = 0;
        run_cycle();
        while (o_stall_if == 1 && n < 40) begin
            n++;
            run_cycle();
        end
        check_val("div_stall_len", n, DIV_LAT);
        check_val("div_done_release", o_done, 1);

        // Mult followed by mult
        idle_inputs();
        valid_id = 1'b1; mdu_start_id = 1'b1;
        run_cycle();
        n = 0;
        run_cycle();
        while (o_stall_if == 1 && n < 10) begin
            n++;
            run_cycle();
        end
        check_val("mul_stall_len", n, MUL_LAT);
        check_val("mul2_accept_done", o_done, 1);
        idle_inputs();
        n = 0;
        run_cycle();
        while (o_busy == 1 && n < 10) begin
            n++;
            run_cycle();
        end
        check_val("mul2_busy_len", n, MUL_LAT);
        check_val("mul2_done", o_done, 1);

        // Branch overrides load-use stall and squashes an MDU start
        idle_inputs();
        valid_ex = 1'b1; mem_to_reg_ex = 1'b1; reg_wr_ex = 1'b1; wr_reg_ex = 5'd3;
        valid_id = 1'b1; rt_id = 5'd3; mdu_start_id = 1'b1; branch_taken_ex = 1'b1;
        run_cycle();
        check_val("br_stall_if", o_stall_if, 0);
        check_val("br_clr_id", o_clr_id, 1);
        check_val("br_clr_ex", o_clr_ex, 1);
        idle_inputs();
        run_cycle();
        check_val("br_no_start", o_busy, 0);

        // Reset while a divide is running (counter at 17)
        idle_inputs();
        valid_id = 1'b1; mdu_start_id = 1'b1; mdu_is_div_id = 1'b1;
        run_cycle();
        idle_inputs();
        for (int i = 0; i < 14; i++) run_cycle();
        check_val("pre_reset_busy", o_busy, 1);
        reset = 1'b1;
        run_cycle();
        check_val("rst_clr_ex", o_clr_ex, 1);
        reset = 1'b0;
        run_cycle();
        check_val("rst_busy_clear", o_busy, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            n += o_done;
        end
        check_val("rst_no_done", n, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
